// File: rtl/bundle_reader_pkg.sv
// bundle_pkg: shared state enum, default widths and the writer's bit-update rule
package bundle_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_IDX_W = 2;
  localparam int MAX_W = 32;
  // Writer update rule: inp with bit idx replaced by out; callers size to their own width.
  function automatic logic [MAX_W-1:0] next_inp(input logic [MAX_W-1:0] inp, input logic [4:0] idx,
                                                input logic out);
    logic [MAX_W-1:0] r;
    r = inp;
    r[idx] = out;
    return r;
  endfunction
endpackage

// File: rtl/bundle_reader_if.sv
// bundle_reader_if: parity-feedback bundle plus snapshot valid/ready stream
//  master: writer/consumer side (drives b_index, b_inp, b_out, snap_ready)
//  slave:  reader side (drives snap_valid, snap_data)
interface bundle_reader_if import bundle_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
);
  logic [IDX_W-1:0] b_index;
  logic [WIDTH-1:0] b_inp;
  logic b_out;
  logic snap_valid;
  logic snap_ready;
  logic [WIDTH-1:0] snap_data;
  modport master (output b_index, b_inp, b_out, snap_ready, input snap_valid, snap_data);
  modport slave (input b_index, b_inp, b_out, snap_ready, output snap_valid, snap_data);
endinterface

// File: rtl/bundle_reader_snap_fifo.sv
// snap_fifo: 2-deep valid/ready FIFO whose outputs come straight from the head register
//  clk, rst_n (async active-low) | push, din in | ready in | valid, dout, full out
module snap_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             full
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d, h;
  logic head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic pop, h_v, t_v, acc;
  // Pop first (tail shifts into head), then place an accepted push in the first free slot.
  always_comb begin
    pop = head_v_q && ready;
    h_v = pop ? tail_v_q : head_v_q;
    h = pop ? tail_q : head_q;
    t_v = pop ? 1'b0 : tail_v_q;
    acc = push && !t_v;
    head_v_d = h_v || acc;
    head_d = (acc && !h_v) ? din : h;
    tail_v_d = t_v || (acc && h_v);
    tail_d = (acc && h_v) ? din : tail_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      head_v_q <= head_v_d;
      tail_v_q <= tail_v_d;
    end
  assign valid = head_v_q;
  assign dout = head_q;
  assign full = head_v_q && tail_v_q;
endmodule

// File: rtl/bundle_reader.sv
// bundle_reader: passive checker of the parity-feedback bundle with lock tracking and sweep snapshots
//  b_clock, reset_n (async active-low) | bus: bundle in, snapshot stream out
//  locked, err, err_count, drop_count: status outputs
module bundle_reader import bundle_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int LOCK_N = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 b_clock,
  input  logic                 reset_n,
  bundle_reader_if.slave       bus,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] drop_count
);
  localparam int GW = $clog2(LOCK_N + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] pred_inp_q, pred_inp_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic locked_q, locked_d, err_q, err_d;
  logic mismatch, push, drop, fifo_full;
  always_ff @(posedge b_clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pred_inp_q <= '0;
      pred_idx_q <= '0;
      good_q <= '0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pred_inp_q <= pred_inp_d;
      pred_idx_q <= pred_idx_d;
      good_q <= good_d;
      locked_q <= locked_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  // Prediction checks only exist once a previous sample has loaded the shadow (state left IDLE).
  always_comb begin
    mismatch = (bus.b_out != ^bus.b_inp) ||
               (state_q != IDLE && (bus.b_inp != pred_inp_q || bus.b_index != pred_idx_q));
    pred_inp_d = WIDTH'(next_inp(MAX_W'(bus.b_inp), 5'(bus.b_index), bus.b_out));
    pred_idx_d = bus.b_index + IDX_W'(1);
    good_inc = good_q + GW'(1);
    state_d = mismatch ? FAULT : (state_q != FAULT || good_inc == GW'(LOCK_N)) ? TRACK : FAULT;
    good_d = (state_q == FAULT && !mismatch && good_inc != GW'(LOCK_N)) ? good_inc : '0;
  end
  always_comb begin
    locked_d = state_d == TRACK;
    err_d = err_q || mismatch;
    err_cnt_d = err_cnt_q + ERR_CNT_W'(mismatch && err_cnt_q != '1);
    push = state_q == TRACK && bus.b_index == '0 && !mismatch;
    drop = push && fifo_full && !(bus.snap_valid && bus.snap_ready);
    drop_cnt_d = drop_cnt_q + ERR_CNT_W'(drop && drop_cnt_q != '1);
  end
  snap_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk(b_clock),
    .rst_n(reset_n),
    .push(push),
    .din(bus.b_inp),
    .ready(bus.snap_ready),
    .valid(bus.snap_valid),
    .dout(bus.snap_data),
    .full(fifo_full)
  );
  assign locked = locked_q;
  assign err = err_q;
  assign err_count = err_cnt_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_bundle_reader.sv
// tb_bundle_reader: directed and random bundle traffic checked against a behavioural model
module tb_bundle_reader;
  localparam int W = 4;
  localparam int IW = 2;
  localparam int LN = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [IW-1:0] idx;
  logic [W-1:0] inp;
  logic out, rdy;
  logic locked, err, locked2, err2;
  logic [7:0] errc, dropc;
  logic [1:0] errc2, dropc2;
  bundle_reader_if #(.WIDTH(W), .IDX_W(IW)) bus ();
  bundle_reader_if #(.WIDTH(W), .IDX_W(IW)) bus2 ();
  assign bus.b_index = idx;
  assign bus.b_inp = inp;
  assign bus.b_out = out;
  assign bus.snap_ready = rdy;
  assign bus2.b_index = idx;
  assign bus2.b_inp = inp;
  assign bus2.b_out = out;
  assign bus2.snap_ready = rdy;
  bundle_reader #(.WIDTH(W), .IDX_W(IW), .LOCK_N(LN), .ERR_CNT_W(8)) dut (
    .b_clock(clk), .reset_n(rst_n), .bus(bus),
    .locked(locked), .err(err), .err_count(errc), .drop_count(dropc));
  bundle_reader #(.WIDTH(W), .IDX_W(IW), .LOCK_N(LN), .ERR_CNT_W(2)) dut2 (
    .b_clock(clk), .reset_n(rst_n), .bus(bus2),
    .locked(locked2), .err(err2), .err_count(errc2), .drop_count(dropc2));
  int checks = 0;
  int errors = 0;
  // Model: mode 0 = no sample yet, 1 = locked, 2 = recovering
  int mode, good, merrc, merrc2, mdrop, pidx, widx;
  logic merr;
  logic [W-1:0] pinp, winp;
  logic [W-1:0] q[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mode = 0; good = 0; merr = 1'b0; merrc = 0; merrc2 = 0; mdrop = 0; pidx = 0; pinp = '0;
    q.delete();
  endtask
  task automatic model_step();
    logic mm, pop, psh;
    mm = (out != ^inp) || (mode != 0 && (inp != pinp || int'(idx) != pidx));
    pop = q.size() > 0 && rdy;
    psh = mode == 1 && idx == 0 && !mm;
    if (pop) void'(q.pop_front());
    if (psh) begin
      if (q.size() < 2) q.push_back(inp);
      else mdrop = mdrop < 255 ? mdrop + 1 : 255;
    end
    if (mm) begin
      merr = 1'b1;
      merrc = merrc < 255 ? merrc + 1 : 255;
      merrc2 = merrc2 < 3 ? merrc2 + 1 : 3;
      mode = 2;
      good = 0;
    end else if (mode == 0) mode = 1;
    else if (mode == 2) begin
      good++;
      if (good == LN) begin mode = 1; good = 0; end
    end
    pinp = inp;
    pinp[idx] = out;
    pidx = (int'(idx) + 1) % W;
  endtask
  task automatic compare_all();
    check("locked", 32'(locked), 32'(mode == 1));
    check("err", 32'(err), 32'(merr));
    check("err_count", 32'(errc), 32'(merrc));
    check("err_count_w2", 32'(errc2), 32'(merrc2));
    check("drop_count", 32'(dropc), 32'(mdrop));
    check("snap_valid", 32'(bus.snap_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("snap_data", 32'(bus.snap_data), 32'(q[0]));
  endtask
  // One clock: drive the writer (optionally corrupted), let the edge happen, model it, check.
  task automatic cycle(input logic flip, input logic [W-1:0] corrupt, input logic r, input int jump);
    idx = IW'(widx + jump);
    inp = winp ^ corrupt;
    out = (^inp) ^ flip;
    rdy = r;
    @(posedge clk);
    model_step();
    winp = inp;
    winp[idx] = out;
    widx = (int'(idx) + 1) % W;
    #1;
    compare_all();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_errc"}, 32'(errc), 0);
    check({tag, "_dropc"}, 32'(dropc), 0);
    check({tag, "_valid"}, 32'(bus.snap_valid), 0);
    check({tag, "_data"}, 32'(bus.snap_data), 0);
    check({tag, "_dut2"}, 32'({locked2, err2, errc2, dropc2, bus2.snap_valid, bus2.snap_data}), 0);
  endtask
  initial begin
    int base;
    idx = '0; inp = '0; out = 1'b0; rdy = 1'b1;
    model_reset();
    winp = 4'b1111;
    widx = 0;
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 0);
    check("t1_locked_first", 32'(locked), 1);
    check("t1_no_push_idle", 32'(bus.snap_valid), 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 0);
    check("t1_first_snap_valid", 32'(bus.snap_valid), 1);
    check("t1_first_snap_data", 32'(bus.snap_data), 32'h e);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 0);
    check("t1_err_clean", 32'(err), 0);
    cycle(1'b1, '0, 1'b1, 0);
    check("t2_err", 32'(err), 1);
    check("t2_errc", 32'(errc), 1);
    check("t2_unlocked", 32'(locked), 0);
    cycle(1'b0, '0, 1'b1, 0);
    cycle(1'b0, '0, 1'b1, 0);
    check("t2_still_fault", 32'(locked), 0);
    cycle(1'b0, '0, 1'b1, 0);
    check("t2_relocked", 32'(locked), 1);
    for (int i = 0; i < 8 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 0);
    check("t3_drained", 32'(q.size()), 0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 0);
    check("t3_drop", 32'(dropc), 1);
    check("t3_held", 32'(bus.snap_valid), 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 0);
    for (int i = 0; i < 20 && q.size() < 2; i++) cycle(1'b0, '0, 1'b0, 0);
    for (int i = 0; i < 4 && widx != 0; i++) cycle(1'b0, '0, 1'b0, 0);
    check("t4_full", 32'(q.size()), 2);
    base = mdrop;
    cycle(1'b0, '0, 1'b1, 0);
    check("t4_drop_same", 32'(dropc), 32'(base));
    check("t4_still_two", 32'(q.size()), 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 0);
    base = merrc;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, '0, 1'b1, 0);
      cycle(1'b0, '0, 1'b1, 0);
    end
    check("t5_sat", 32'(errc2), 3);
    check("t5_errc", 32'(errc), 32'(base + 5));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 0);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(15) == 0), ($urandom_range(15) == 0) ? W'($urandom) : '0,
            1'($urandom_range(3) != 0), ($urandom_range(31) == 0) ? 1 : 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 0);
    cycle(1'b0, '0, 1'b1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 0);
    check("t6_locked", 32'(locked), 1);
    check("t6_no_snap", 32'(bus.snap_valid), 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
